// File: rtl/encrypted_tx_packetizer.sv
// Drains one full block of ciphertext from the encrypted-data FIFO and frames it
// as a USB data packet (DATA0/DATA1 PID, payload, CRC16 low byte first).
module encrypted_tx_packetizer #(
  parameter int unsigned PAYLOAD_BYTES = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_enable,
  input  logic       clear_toggle,
  input  logic [7:0] fifo_r_data,
  input  logic       fifo_empty,
  input  logic       fifo_full,
  output logic       fifo_r_enable,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_last,
  output logic       pkt_done,
  output logic       busy
);

  localparam int unsigned CNT_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_BYTES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PID     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CRC_LO  = 3'd3;
  localparam logic [2:0] S_CRC_HI  = 3'd4;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  logic [2:0]       state;
  logic             toggle;
  logic [15:0]      crc;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0]       pid;
  logic             accept;

  // Reflected USB CRC16 (poly 16'hA001), one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[0] ^ d[3'(i)];
      c  = (c >> 1) ^ (fb ? 16'hA001 : 16'h0000);
    end
    return c;
  endfunction

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_last  = 1'b0;
    case (state)
      S_PID: begin
        tx_valid = 1'b1;
        tx_data  = pid;
      end
      S_PAYLOAD: begin
        tx_valid = ~fifo_empty;
        tx_data  = fifo_r_data;
      end
      S_CRC_LO: begin
        tx_valid = 1'b1;
        tx_data  = ~crc[7:0];
      end
      S_CRC_HI: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = ~crc[15:8];
      end
      default: ;
    endcase
  end

  assign accept        = tx_valid & tx_ready;
  assign fifo_r_enable = (state == S_PAYLOAD) & accept;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      toggle   <= 1'b0;
      crc      <= 16'hFFFF;
      byte_cnt <= '0;
      pid      <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_enable && fifo_full) begin
            pid      <= toggle ? PID_DATA1 : PID_DATA0;
            crc      <= 16'hFFFF;
            byte_cnt <= '0;
            state    <= S_PID;
          end
        end
        S_PID: begin
          if (accept) state <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (accept) begin
            crc <= crc16_byte(crc, fifo_r_data);
            // Last byte leaves the counter parked so it never wraps in-packet.
            if (byte_cnt == LAST_CNT) state <= S_CRC_LO;
            else                      byte_cnt <= byte_cnt + CNT_W'(1);
          end
        end
        S_CRC_LO: begin
          if (accept) state <= S_CRC_HI;
        end
        S_CRC_HI: begin
          if (accept) begin
            state    <= S_IDLE;
            pkt_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // clear_toggle takes priority over the end-of-packet flip.
      if (clear_toggle)                     toggle <= 1'b0;
      else if (state == S_CRC_HI && accept) toggle <= ~toggle;
    end
  end

endmodule

// File: tb/tb_encrypted_tx_packetizer.sv
// Bench for encrypted_tx_packetizer: behavioural FIFO, randomized data/stalls,
// packet reference model built from a non-reflected CRC16 formulation.
module tb_encrypted_tx_packetizer;

  logic       clk;
  logic       n_rst;
  logic       tx_enable;
  logic       clear_toggle;
  logic [7:0] fifo_r_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_r_enable;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       tx_last;
  logic       pkt_done;
  logic       busy;

  encrypted_tx_packetizer #(.PAYLOAD_BYTES(16)) dut (
    .clk(clk), .n_rst(n_rst), .tx_enable(tx_enable), .clear_toggle(clear_toggle),
    .fifo_r_data(fifo_r_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_r_enable(fifo_r_enable), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last), .pkt_done(pkt_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural 16-deep FIFO feeding the DUT
  logic [7:0] mem [32];
  logic [5:0] wr_ptr, rd_ptr;
  logic       push_en = 1'b0;
  logic [7:0] push_data = '0;
  logic       fifo_flush = 1'b1;
  logic       force_empty = 1'b0;

  always @(posedge clk) begin
    if (fifo_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_r_enable) rd_ptr <= rd_ptr + 6'd1;
      if (push_en) begin
        mem[wr_ptr[4:0]] <= push_data;
        wr_ptr <= wr_ptr + 6'd1;
      end
    end
  end

  assign fifo_r_data = mem[rd_ptr[4:0]];
  assign fifo_empty  = (wr_ptr == rd_ptr) || force_empty;
  assign fifo_full   = (6'(wr_ptr - rd_ptr) == 6'd16);

  bit rand_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: record accepted bytes, count pops and pkt_done, check stall stability
  logic [8:0] got_q[$];
  int         pop_cnt = 0;
  int         done_cnt = 0;
  bit         stalled = 1'b0;
  logic [7:0] st_data;
  logic       st_last;

  always @(negedge clk) begin
    if (fifo_r_enable) begin
      pop_cnt++;
      check("pop_ok", {31'd0, fifo_empty || !(tx_valid && tx_ready)}, 32'd0);
    end
    if (pkt_done) begin
      done_cnt++;
      check("done_idle", {31'd0, busy}, 32'd0);
    end
    if (tx_valid && tx_ready) got_q.push_back({tx_last, tx_data});
    if (stalled && n_rst && !force_empty) begin
      check("stall_valid", {31'd0, tx_valid}, 32'd1);
      check("stall_data", {24'd0, tx_data}, {24'd0, st_data});
      check("stall_last", {31'd0, tx_last}, {31'd0, st_last});
    end
    stalled = tx_valid && !tx_ready && n_rst;
    st_data = tx_data;
    st_last = tx_last;
  end

  // Reference model: reflected CRC via bit-reversed MSB-first CRC16 (poly 8005)
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  function automatic logic [15:0] crc_ref(input logic [7:0] bytes[$]);
    logic [15:0] c;
    logic [7:0]  rb;
    logic        fb;
    c = 16'hFFFF;
    foreach (bytes[k]) begin
      rb = rev8(bytes[k]);
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ rb[b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    return rev16(c);
  endfunction

  logic [7:0] blk [16];
  bit         m_toggle = 1'b0;

  task automatic clear_stats();
    got_q.delete();
    pop_cnt  = 0;
    done_cnt = 0;
  endtask

  // Entered and left at posedge+1
  task automatic push_block();
    for (int i = 0; i < 16; i++) begin
      push_data = blk[i];
      push_en   = 1'b1;
      @(posedge clk); #1;
    end
    push_en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int  start;
    bit  seen;
    start = done_cnt;
    seen  = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      if (done_cnt != start) seen = 1'b1;
    end
    if (!seen) check("timeout_pkt_done", 32'd0, 32'd1);
    #1;
  endtask

  task automatic compare_pkt(input logic [7:0] pid, input bit residual);
    logic [7:0]  exp_b [19];
    logic [7:0]  q[$];
    logic [15:0] c;
    for (int i = 0; i < 16; i++) q.push_back(blk[i]);
    c = crc_ref(q);
    exp_b[0] = pid;
    for (int i = 0; i < 16; i++) exp_b[i+1] = blk[i];
    exp_b[17] = ~c[7:0];
    exp_b[18] = ~c[15:8];
    check("pkt_len", got_q.size(), 32'd19);
    for (int i = 0; i < 19 && i < got_q.size(); i++) begin
      check($sformatf("byte%0d", i), {24'd0, got_q[i][7:0]}, {24'd0, exp_b[i]});
      check($sformatf("last%0d", i), {31'd0, got_q[i][8]}, (i == 18) ? 32'd1 : 32'd0);
    end
    check("pops", pop_cnt, 32'd16);
    check("done_pulses", done_cnt, 32'd1);
    if (residual && got_q.size() >= 19) begin
      q.push_back(got_q[17][7:0]);
      q.push_back(got_q[18][7:0]);
      check("crc_residual", {16'd0, crc_ref(q)}, 32'h0000B001);
    end
  endtask

  task automatic run_pkt(input bit random_data);
    if (random_data) for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
    else             for (int i = 0; i < 16; i++) blk[i] = 8'(i);
    clear_stats();
    push_block();
    wait_done(400);
    compare_pkt(m_toggle ? 8'h4B : 8'hC3, 1'b0);
    m_toggle = ~m_toggle;
  endtask

  initial begin
    bit hit;
    n_rst        = 1'b0;
    tx_enable    = 1'b1;
    clear_toggle = 1'b0;
    @(posedge clk); #1;
    fifo_flush = 1'b0;

    // Reset held while a full block sits in the FIFO
    for (int i = 0; i < 16; i++) blk[i] = 8'(i);
    push_block();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_full", {31'd0, fifo_full}, 32'd1);
      check("rst_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_ren", {31'd0, fifo_r_enable}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    clear_stats();
    n_rst = 1'b1;

    // Counting block: PID offered one cycle after start, CRC residual check
    @(negedge clk);
    check("start_idle", {31'd0, tx_valid}, 32'd0);
    @(negedge clk);
    check("pid_valid", {31'd0, tx_valid}, 32'd1);
    check("pid_data", {24'd0, tx_data}, 32'h000000C3);
    check("pid_busy", {31'd0, busy}, 32'd1);
    wait_done(100);
    compare_pkt(8'hC3, 1'b1);
    m_toggle = ~m_toggle;

    // Second block -> DATA1, then clear_toggle -> DATA0 again
    run_pkt(1'b1);
    clear_toggle = 1'b1;
    @(posedge clk); #1;
    clear_toggle = 1'b0;
    m_toggle = 1'b0;
    run_pkt(1'b1);

    // Random stalls
    rand_mode = 1'b1;
    run_pkt(1'b0);
    run_pkt(1'b1);
    run_pkt(1'b1);
    rand_mode = 1'b0;
    @(posedge clk); #1;

    // FIFO underflow after byte 8
    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
    clear_stats();
    push_block();
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk);
      if (pop_cnt == 9) hit = 1'b1;
    end
    check("underflow_reach", {31'd0, hit}, 32'd1);
    #1;
    force_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("uf_valid", {31'd0, tx_valid}, 32'd0);
      check("uf_ren", {31'd0, fifo_r_enable}, 32'd0);
      check("uf_busy", {31'd0, busy}, 32'd1);
    end
    @(posedge clk); #1;
    force_empty = 1'b0;
    wait_done(100);
    compare_pkt(m_toggle ? 8'h4B : 8'hC3, 1'b0);
    m_toggle = ~m_toggle;

    // Reset mid-payload with toggle currently 1
    check("pre_rst_toggle_model", {31'd0, m_toggle}, 32'd1);
    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
    clear_stats();
    push_block();
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk);
      if (pop_cnt == 5) hit = 1'b1;
    end
    check("midrst_reach", {31'd0, hit}, 32'd1);
    #1;
    n_rst      = 1'b0;
    fifo_flush = 1'b1;
    @(posedge clk); #1;
    n_rst      = 1'b1;
    fifo_flush = 1'b0;
    m_toggle   = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, tx_valid}, 32'd0);
    check("midrst_no_done", done_cnt, 32'd0);
    @(posedge clk); #1;
    run_pkt(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
